// File: rtl/light_rx_if.sv
// light_rx host-side bundle: optical line in, frame and status out.
// master drives the line and acknowledge; slave is the receiver.
interface light_rx_if #(
  parameter int FRAME_SIZE = 16
);
  logic                  signal;
  logic                  irq_ack;
  logic [FRAME_SIZE-1:0] data_out;
  logic                  irq_rx;
  logic                  overrun;
  logic                  frame_error;
  logic                  parity_error;

  modport master (
    output signal, irq_ack,
    input  data_out, irq_rx, overrun,
    input  frame_error, parity_error
  );

  modport slave (
    input  signal, irq_ack,
    output data_out, irq_rx, overrun,
    output frame_error, parity_error
  );
endinterface

// File: rtl/light_rx.sv
// LightIO optical receiver: oversampled start/data/stop frame recovery.
// Optional even parity bit enabled by defining LIGHTIO_RX_PARITY_EN.
module light_rx #(
  parameter int FRAME_SIZE = 16,
  parameter int OVERSAMPLE = 4
) (
  input logic     clock,
  input logic     reset,
  light_rx_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(FRAME_SIZE + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_SIZE - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] STOP     = 3'd3;
  localparam logic [2:0] WAIT_LOW = 3'd4;
`ifdef LIGHTIO_RX_PARITY_EN
  localparam logic [2:0] PARITY   = 3'd5;
`endif

  logic [2:0]            sync_q;
  logic                  sig_s;
  logic                  sig_prev;
  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bits_q, bits_d;
  logic [FRAME_SIZE-1:0] shift_q, shift_d;
  logic [FRAME_SIZE-1:0] data_q, data_d;
  logic                  irq_q, irq_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;
`ifdef LIGHTIO_RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  perr_q, perr_d;
`endif

  assign sig_s    = sync_q[1];
  assign sig_prev = sync_q[2];

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], bus.signal};
  end

  // Frame FSM next-state, shifting and host flag handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    data_d  = data_q;
    irq_d   = irq_q;
    ovr_d   = ovr_q;
    ferr_d  = 1'b0;
`ifdef LIGHTIO_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (bus.irq_ack) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (sig_s && !sig_prev) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bits_d  = '0;
          ferr_d  = !sig_s;
          state_d = sig_s ? DATA : IDLE;
`ifdef LIGHTIO_RX_PARITY_EN
          par_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {shift_q[FRAME_SIZE-2:0], sig_s};
          bits_d  = bits_q + BW'(1);
`ifdef LIGHTIO_RX_PARITY_EN
          par_d   = par_q ^ sig_s;
          if (bits_q == LAST_BIT) state_d = PARITY;
`else
          if (bits_q == LAST_BIT) state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef LIGHTIO_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          par_d   = par_q ^ sig_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (sig_s) begin
            ferr_d  = 1'b1;
            state_d = WAIT_LOW;
          end else begin
            state_d = IDLE;
`ifdef LIGHTIO_RX_PARITY_EN
            if (par_q) begin
              perr_d = 1'b1;
            end else begin
              data_d = shift_q;
              ovr_d  = bus.irq_ack ? 1'b0 : (ovr_q | irq_q);
              irq_d  = 1'b1;
            end
`else
            data_d = shift_q;
            ovr_d  = bus.irq_ack ? 1'b0 : (ovr_q | irq_q);
            irq_d  = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LOW: begin
        if (!sig_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef LIGHTIO_RX_PARITY_EN
  // Parity accumulator and error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign bus.parity_error = perr_q;
`else
  assign bus.parity_error = 1'b0;
`endif

  assign bus.data_out    = data_q;
  assign bus.irq_rx      = irq_q;
  assign bus.overrun     = ovr_q;
  assign bus.frame_error = ferr_q;
endmodule

// File: tb/tb_light_rx.sv
// Bench for light_rx: directed cases plus random frames vs a flag model.
// Inputs change on negedge; outputs are checked on negedge or #1 after posedge.
module tb_light_rx;
  localparam int FS = 16;
  localparam int OS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   ferr_cnt = 0;
  int   perr_cnt = 0;

  logic [FS-1:0] m_data = '0;
  logic          m_irq = 1'b0;
  logic          m_ovr = 1'b0;
  int            m_ferr = 0;
  int            m_perr = 0;

  light_rx_if #(.FRAME_SIZE(FS)) bus ();

  light_rx #(.FRAME_SIZE(FS), .OVERSAMPLE(OS)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.frame_error === 1'b1) ferr_cnt++;
    if (bus.parity_error === 1'b1) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"}, 32'(bus.data_out), 32'(m_data));
    check({tag, ".irq"}, 32'(bus.irq_rx), 32'(m_irq));
    check({tag, ".ovr"}, 32'(bus.overrun), 32'(m_ovr));
    check({tag, ".ferr"}, 32'(ferr_cnt), 32'(m_ferr));
    check({tag, ".perr"}, 32'(perr_cnt), 32'(m_perr));
  endtask

  task automatic send_bit(input logic v);
    bus.signal = v;
    repeat (OS) @(negedge clk);
  endtask

  task automatic ack_pulse();
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    m_irq = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Whole frame on the line; signal is raised right after a negedge, so
  // the next posedge is the first to see it.  Commit lands on posedge
  // 3 + OS/2 + (FS+1)*OS (+OS with parity), counting that one as 1.
  task automatic send_frame(input string tag, input logic [FS-1:0] d,
                            input bit bad_stop, input bit pflip,
                            input bit ack_commit);
    bit commit;
    send_bit(1'b1);
    for (int i = FS - 1; i >= 0; i--) send_bit(d[i]);
`ifdef LIGHTIO_RX_PARITY_EN
    send_bit((^d) ^ pflip);
    commit = !pflip;
`else
    commit = 1'b1;
`endif
    if (bad_stop) begin
      repeat (10) send_bit(1'b1);
      bus.signal = 1'b0;
      m_ferr++;
      repeat (3) @(negedge clk);
      check_all({tag, ".badstop"});
      return;
    end
    send_bit(1'b0);
    check({tag, ".pre_irq"}, 32'(bus.irq_rx), 32'(m_irq));
    bus.irq_ack = ack_commit;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    if (commit) begin
      m_ovr = ack_commit ? 1'b0 : (m_ovr | m_irq);
      m_irq = 1'b1;
      m_data = d;
    end else begin
      m_perr++;
      if (ack_commit) begin
        m_irq = 1'b0;
        m_ovr = 1'b0;
      end
    end
    check_all(tag);
  endtask

  initial begin
    logic [FS-1:0] d;
    bit pf;
    bus.signal = 1'b0;
    bus.irq_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send_frame("good", 16'h5045, 0, 0, 0);

    send_frame("a5a5", 16'hA5A5, 0, 0, 0);
    send_frame("ovr", 16'h0001, 0, 0, 0);
    ack_pulse();
    check_all("ack");

    send_frame("pend", 16'h1111, 0, 0, 0);
    send_frame("ackwin", 16'h2222, 0, 0, 1);
    ack_pulse();

    bus.signal = 1'b1;
    @(negedge clk);
    bus.signal = 1'b0;
    m_ferr++;
    repeat (8) @(negedge clk);
    check_all("glitch");
    send_frame("after_glitch", 16'h00FF, 0, 0, 0);
    ack_pulse();

    send_frame("f1234", 16'h1234, 1, 0, 0);
    send_bit(1'b0);
    send_frame("f4321", 16'h4321, 0, 0, 0);

    send_bit(1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_data = '0;
    m_irq = 1'b0;
    m_ovr = 1'b0;
    check_all("midreset");
    @(negedge clk);
    bus.signal = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all("released");
    send_frame("f8001", 16'h8001, 0, 0, 0);
    ack_pulse();

`ifdef LIGHTIO_RX_PARITY_EN
    send_frame("par_ok", 16'h0003, 0, 0, 0);
    ack_pulse();
    send_frame("par_bad", 16'h0001, 0, 1, 0);
`endif

    for (int n = 0; n < 12; n++) begin
      d = FS'($urandom);
      if ($urandom_range(0, 1) == 1) ack_pulse();
      repeat ($urandom_range(0, 3)) @(negedge clk);
`ifdef LIGHTIO_RX_PARITY_EN
      pf = ($urandom_range(0, 3) == 0);
`else
      pf = 1'b0;
`endif
      send_frame("rand", d, 0, pf, $urandom_range(0, 4) == 0);
    end

    repeat (4) @(negedge clk);
    check_all("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule

// File: doc/light_rx.md
Name: light_rx

Overview:
- Standalone receive half of the LightIO optical link.
- Recovers one FRAME_SIZE-bit frame from the photodetector input `signal`, which the far-end transceiver drives through its `led` output.
- Presents the frame on data_out and raises irq_rx until acknowledged.
- Sits beside the existing transmit path; pairs with a transceiver's led output on the board or in system benches.

Parameters:
- FRAME_SIZE, 16, payload bits per frame (matches `FRAME_SIZE in definitions.v).
- OVERSAMPLE, 4, clock cycles per line bit; even, >= 4.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- signal  input  1  raw optical line; asynchronous to clock.
- irq_ack  input  1  host acknowledge; clears irq_rx and overrun.
- data_out  output  FRAME_SIZE  last good frame, MSB = first received bit.
- irq_rx  output  1  frame-ready flag; level, sticky until irq_ack.
- overrun  output  1  sticky; a good frame completed while irq_rx was already 1.
- frame_error  output  1  one-cycle pulse on bad stop bit or glitch start.
- parity_error  output  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Line format: idle 0, start bit 1, FRAME_SIZE data bits MSB first, stop bit 0; each bit lasts OVERSAMPLE clocks.
- Synchronizer: signal passes through 2 flops to give sig_s; all decisions use sig_s.
- Reset (reset=0, asynchronous):
  - state=IDLE; counters=0; shift register=0.
  - data_out=0, irq_rx=0, overrun=0, frame_error=0, parity_error=0.
  - Reset mid-frame discards the partial frame; no flags are raised.
- FSM states: IDLE, START, DATA, STOP, WAIT_LOW.
- IDLE:
  - sig_s rising edge (previous sample 0, current 1) -> START; clear cycle counter.
  - Steady 1 is not a start.
- START:
  - After OVERSAMPLE/2 cycles, sample sig_s.
  - 1 -> DATA, bit count=0.
  - 0 -> glitch: pulse frame_error, go to IDLE.
- DATA:
  - Every OVERSAMPLE cycles, sample sig_s and shift into the LSB.
  - After FRAME_SIZE samples -> STOP (-> PARITY first when the feature is enabled).
- STOP:
  - After OVERSAMPLE cycles, sample sig_s.
  - 0 -> commit:
    - data_out <= shift register.
    - If irq_rx is already 1, set overrun; data_out is still overwritten.
    - irq_rx <= 1; go to IDLE.
  - 1 -> pulse frame_error; data_out and irq_rx unchanged; go to WAIT_LOW.
- WAIT_LOW: stay until sig_s=0, then IDLE. Prevents false start on a stuck-high line.
- Latency:
  - irq_rx rises exactly 3 + OVERSAMPLE/2 + (FRAME_SIZE+1)*OVERSAMPLE clocks after the first clock edge that sees signal=1.
  - Defaults: 73 clocks.
- irq_ack:
  - When 1, clears irq_rx and overrun on the next edge.
  - If a commit occurs in the same cycle, commit wins: irq_rx=1, overrun=0, new data_out.
- Back-to-back frames: a new start is accepted on the first IDLE cycle after commit; no gap is required beyond the stop bit.
- Counters saturate never. The cycle counter wraps at OVERSAMPLE-1; the bit counter resets per frame.

Optional Feature:
- Macro: LIGHTIO_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the data bits (state PARITY, sampled after OVERSAMPLE cycles).
  - Parity over data+parity bit must be even.
  - On mismatch: at stop, a good stop still pulses parity_error instead of committing; data_out and irq_rx are unchanged.
  - Latency grows by OVERSAMPLE (77 clocks at defaults).
- Undefined: no PARITY state; parity_error is tied 0.

Test Plan:
- Good frame: drive 16'h5045 at 4 clocks/bit -> irq_rx=1 at clock 73 after the start edge; data_out=16'h5045; frame_error=0; overrun=0.
- Ack/overrun:
  - Send 16'hA5A5; do not ack; send 16'h0001 -> data_out=16'h0001, overrun=1.
  - Pulse irq_ack -> irq_rx=0, overrun=0 next cycle.
- Glitch: 1-clock high pulse on signal -> frame_error pulse ~4 clocks later; FSM returns to IDLE; a following good frame 16'h00FF is received correctly.
- Bad stop: frame 16'h1234 with stop bit 1 held 10 bit-times -> one frame_error pulse; irq_rx stays 0; no restart until the line drops; next frame 16'h4321 received.
- Reset mid-frame: assert reset at data bit 7 of 16'hFFFF -> all outputs 0 immediately; after release, frame 16'h8001 received exactly.
- Parity (macro defined): 16'h0003 with parity 0 -> commit; 16'h0001 with parity 0 -> parity_error pulse, irq_rx stays 0. Macro undefined: parity_error always 0.
